// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter_pkg
//  Purpose  : Shared types and constants for the ALU sharing arbiter:
//             FSM state encoding, default widths and opcode constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_share_arbiter_pkg;

    localparam int WL_DEF    = 32;
    localparam int OPW_DEF   = 4;
    // Top opcode bit steers the ALU output mux: 0 = arith unit, 1 = logic unit.
    localparam int LOGIC_SEL = OPW_DEF - 1;

    localparam logic [OPW_DEF-1:0] OP_ADD = 4'h1;
    localparam logic [OPW_DEF-1:0] OP_SUB = 4'h2;
    localparam logic [OPW_DEF-1:0] OP_AND = 4'h9;
    localparam logic [OPW_DEF-1:0] OP_OR  = 4'hA;
    localparam logic [OPW_DEF-1:0] OP_XOR = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter_if
//  Purpose  : Bundle of the two requester handshakes, the registered ALU
//             operand bus, the ALU result return and the response channel.
//  Modports : slave  - the arbiter side
//             master - requesters / ALU / response consumer side
//  Revision : 1.0  initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int WL  = 32,
    parameter int OPW = 4
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [WL-1:0]  req0_a;
    logic [WL-1:0]  req0_b;

    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [WL-1:0]  req1_a;
    logic [WL-1:0]  req1_b;

    logic [OPW-1:0] alu_op;
    logic [WL-1:0]  alu_a;
    logic [WL-1:0]  alu_b;
    logic           alu_sel;
    logic [WL-1:0]  alu_result;

    logic           rsp_valid;
    logic           rsp_id;
    logic [WL-1:0]  rsp_data;
    logic           rsp_ready;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_id, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter_rr_arbiter2
//  Purpose  : Two-way round-robin grant, purely combinational.
//  Ports    : valid_i[1:0] request lines
//             prio_i       requester that wins a tie
//             grant_o[1:0] one-hot grant (all zero when nobody requests)
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter_rr_arbiter2 (
    input  wire logic [1:0] valid_i,
    input  wire logic       prio_i,
    output logic      [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        // Only a tie needs arbitration; a lone requester always wins.
        if (&valid_i) begin
            grant_o = prio_i ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Shares one ALU datapath between two requesters. Round-robin
//             grant, registered operands to the ALU, one-cycle execute, then
//             holds the captured result until the consumer takes it.
//  Ports    : clk  - system clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - alu_share_arbiter_if.slave: req0/req1 handshakes,
//                    alu_op/a/b/sel out, alu_result in, rsp_* channel
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WL  = WL_DEF,
    parameter int OPW = OPW_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_share_arbiter_if.slave  bus
);

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic           id_q, id_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [WL-1:0]  alu_a_q, alu_a_d;
    logic [WL-1:0]  alu_b_q, alu_b_d;
    logic           alu_sel_q, alu_sel_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [WL-1:0]  rsp_data_q, rsp_data_d;

    logic [1:0]     w_grant;
    logic [1:0]     w_ready;
    logic           w_accept;
    logic           w_acc_id;

    alu_share_arbiter_rr_arbiter2 u_rr (
        .valid_i ({bus.req1_valid, bus.req0_valid}),
        .prio_i  (prio_q),
        .grant_o (w_grant)
    );

    // Gating with rst keeps both readys low while reset is being applied,
    // so no requester sees a handshake that the reset then discards.
    assign w_ready  = (state_q == ST_IDLE && !rst) ? w_grant : 2'b00;
    assign w_accept = |w_ready;
    assign w_acc_id = w_ready[1];

    assign bus.req0_ready = w_ready[0];
    assign bus.req1_ready = w_ready[1];
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        // Everything holds by default; the ALU operands in particular stay
        // put after use instead of being cleared.
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    alu_op_d  = w_acc_id ? bus.req1_op : bus.req0_op;
                    alu_a_d   = w_acc_id ? bus.req1_a  : bus.req0_a;
                    alu_b_d   = w_acc_id ? bus.req1_b  : bus.req0_b;
                    alu_sel_d = w_acc_id ? bus.req1_op[OPW-1] : bus.req0_op[OPW-1];
                    id_d      = w_acc_id;
                    prio_d    = ~w_acc_id;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // alu_result is combinational from the registered operands,
                // so it is settled by the end of this single cycle.
                rsp_data_d  = bus.alu_result;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Self-checking bench for alu_share_arbiter: table of single-op
//             vectors plus reset, contention, backpressure and reset-in-EXEC
//             sequences. A small ALU model supplies alu_result.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int WL  = 32;
    localparam int OPW = 4;

    logic clk;
    logic rst;

    alu_share_arbiter_if #(.WL(WL), .OPW(OPW)) bus ();

    alu_share_arbiter #(.WL(WL), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU sitting behind the mux.
    function automatic logic [WL-1:0] alu_model(input logic [OPW-1:0] op,
                                                input logic [WL-1:0] a,
                                                input logic [WL-1:0] b);
        logic [WL-1:0] r;
        r = a;
        if (op[OPW-1]) begin
            case (op[2:0])
                3'd1: r = a & b;
                3'd2: r = a | b;
                3'd3: r = a ^ b;
                default: r = a;
            endcase
        end else begin
            case (op[2:0])
                3'd1: r = a + b;
                3'd2: r = a - b;
                default: r = a;
            endcase
        end
        return r;
    endfunction

    assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          id;
        logic [3:0]    op;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   exp_data;
        logic          exp_sel;
    } vec_t;

    vec_t vecs[6];

    // Drive one op from a lone requester and check the whole transaction.
    task automatic run_vec(input vec_t v);
        int  n;
        logic rdy_me, rdy_other;
        bus.req0_op = v.op; bus.req0_a = v.a; bus.req0_b = v.b;
        bus.req1_op = v.op; bus.req1_a = v.a; bus.req1_b = v.b;
        bus.req0_valid = (v.id == 1'b0);
        bus.req1_valid = (v.id == 1'b1);
        bus.rsp_ready  = 1'b1;
        #1;
        n = 0;
        rdy_me = v.id ? bus.req1_ready : bus.req0_ready;
        while (!rdy_me && n < 10) begin
            tick();
            n++;
            rdy_me = v.id ? bus.req1_ready : bus.req0_ready;
        end
        rdy_other = v.id ? bus.req0_ready : bus.req1_ready;
        chk("vec_ready", {31'd0, rdy_me}, 32'd1);
        chk("vec_other_ready", {31'd0, rdy_other}, 32'd0);
        tick();                       // accept edge
        idle_inputs();
        chk("vec_alu_op",  {28'd0, bus.alu_op}, {28'd0, v.op});
        chk("vec_alu_a",   bus.alu_a, v.a);
        chk("vec_alu_b",   bus.alu_b, v.b);
        chk("vec_alu_sel", {31'd0, bus.alu_sel}, {31'd0, v.exp_sel});
        chk("vec_rsp_early", {31'd0, bus.rsp_valid}, 32'd0);
        tick();                       // execute edge
        chk("vec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("vec_rsp_id",    {31'd0, bus.rsp_id}, {31'd0, v.id});
        chk("vec_rsp_data",  bus.rsp_data, v.exp_data);
        tick();                       // response taken
        chk("vec_rsp_drop",  {31'd0, bus.rsp_valid}, 32'd0);
        chk("vec_alu_hold",  bus.alu_a, v.a);
    endtask

    initial begin
        int got;
        int both;
        int n;
        int seen;
        logic order[4];

        n_vec = 0;
        n_err = 0;

        vecs[0] = '{1'b0, 4'h1, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1'b1, 4'h9, 32'hF0F0_0000,  32'h0FF0_0000,  32'h00F0_0000,  1'b1};
        vecs[2] = '{1'b0, 4'h2, 32'd10,         32'd3,          32'd7,          1'b0};
        vecs[3] = '{1'b1, 4'hA, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b1};
        vecs[4] = '{1'b0, 4'h1, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[5] = '{1'b1, 4'hB, 32'hA5A5_A5A5,  32'hFFFF_0000,  32'h5A5A_A5A5,  1'b1};

        // ---- reset with both requesters pushing ----
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0_op = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
        bus.req1_op = OP_AND; bus.req1_a = 32'd3; bus.req1_b = 32'd4;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
            chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        end
        chk("rst_alu_op",    {28'd0, bus.alu_op}, 32'd0);
        chk("rst_alu_a",     bus.alu_a, 32'd0);
        chk("rst_alu_b",     bus.alu_b, 32'd0);
        chk("rst_alu_sel",   {31'd0, bus.alu_sel}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_id",    {31'd0, bus.rsp_id}, 32'd0);
        chk("rst_rsp_data",  bus.rsp_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        idle_inputs();
        tick();

        // ---- table of single-requester ops ----
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // ---- contention: both valid, expect 0,1,0,1 after reset ----
        pulse_reset();
        bus.req0_op = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        bus.req1_op = OP_ADD; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        got  = 0;
        both = 0;
        n    = 0;
        while (got < 4 && n < 40) begin
            if (bus.req0_ready && bus.req1_ready) both++;
            if (bus.req0_ready || bus.req1_ready) begin
                order[got] = bus.req1_ready;
                got++;
            end
            if (got < 4) begin
                tick();
                n++;
            end
        end
        tick();
        idle_inputs();
        chk("cont_accepts", got, 32'd4);
        chk("cont_both_ready", both, 32'd0);
        for (int k = 0; k < got; k++) begin
            chk("cont_order", {31'd0, order[k]}, k[31:0] & 32'd1);
        end
        repeat (4) tick();

        // ---- backpressure in RESP ----
        bus.rsp_ready  = 1'b0;
        bus.req0_op = OP_ADD; bus.req0_a = 32'd100; bus.req0_b = 32'd23;
        bus.req0_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.req0_ready && n < 10) begin
            tick();
            n++;
        end
        chk("bp_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_op = OP_SUB; bus.req1_a = 32'd9; bus.req1_b = 32'd4;
        bus.req1_valid = 1'b1;
        tick();
        chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("bp_rsp_data",  bus.rsp_data, 32'd123);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_hold_data",  bus.rsp_data, 32'd123);
            chk("bp_hold_id",    {31'd0, bus.rsp_id}, 32'd0);
            chk("bp_hold_ready0", {31'd0, bus.req0_ready}, 32'd0);
            chk("bp_hold_ready1", {31'd0, bus.req1_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_release_ready1", {31'd0, bus.req1_ready}, 32'd1);
        bus.req1_valid = 1'b0;
        repeat (2) tick();

        // ---- reset while EXEC holds a req0 op ----
        bus.req0_op = OP_ADD; bus.req0_a = 32'd40; bus.req0_b = 32'd2;
        bus.req0_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.req0_ready && n < 10) begin
            tick();
            n++;
        end
        chk("rx_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();                       // accepted, now in EXEC
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        chk("rx_no_rsp", seen, 32'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rx_prio_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("rx_prio_ready1", {31'd0, bus.req1_ready}, 32'd0);
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
